// File: rtl/videosync_gen_if.sv
// ---------------------------------------------------------------------------
// videosync_gen_if
// Bundle of the video timing generator's pixel-rate signals.
//   CE_PIX       pixel clock enable (consumer -> generator)
//   VMODE        requested standard, 0=NTSC 1=PAL (consumer -> generator)
//   PIXELC       current pixel count, HW bits
//   RASTERC      current line count, VW bits
//   FIELD        odd/even line flag
//   HSYNC/VSYNC  active-low syncs (pipeline delayed)
//   HBLANK/VBLANK active-high blanks (pipeline delayed)
//   LINE_START, FRAME_START  one-clock pulses
//   VMODE_ACT    standard currently in effect
// Modports: master = generator side, slave = consumer side.
// ---------------------------------------------------------------------------
interface videosync_gen_if #(
    parameter int HW = 9,
    parameter int VW = 9
);
    logic          CE_PIX;
    logic          VMODE;
    logic [HW-1:0] PIXELC;
    logic [VW-1:0] RASTERC;
    logic          FIELD;
    logic          HSYNC;
    logic          VSYNC;
    logic          HBLANK;
    logic          VBLANK;
    logic          LINE_START;
    logic          FRAME_START;
    logic          VMODE_ACT;

    modport master (
        input  CE_PIX, VMODE,
        output PIXELC, RASTERC, FIELD, HSYNC, VSYNC, HBLANK, VBLANK,
               LINE_START, FRAME_START, VMODE_ACT
    );

    modport slave (
        output CE_PIX, VMODE,
        input  PIXELC, RASTERC, FIELD, HSYNC, VSYNC, HBLANK, VBLANK,
               LINE_START, FRAME_START, VMODE_ACT
    );
endinterface

// File: rtl/videosync_gen.sv
// ---------------------------------------------------------------------------
// videosync_gen
// NTSC/PAL raster timing generator. Counts pixels and lines on CE_PIX,
// decodes sync and blank windows from the counters and delays them by
// SYNC_DLY pixel enables so they line up with a downstream pixel pipeline.
// Ports:
//   CLK    system clock, rising edge
//   RESET  synchronous active-high reset
//   bus    videosync_gen_if.master (CE_PIX, VMODE in; counters, syncs,
//          blanks, line/frame pulses, VMODE_ACT out)
// ---------------------------------------------------------------------------
module videosync_gen #(
    parameter int            HW           = 9,
    parameter int            VW           = 9,
    parameter logic [HW-1:0] H_FIRST      = 9'h080,
    parameter logic [HW-1:0] H_LAST       = 9'h1FF,
    parameter logic [HW-1:0] HBLANK_FIRST = 9'h1C0,
    parameter logic [HW-1:0] HBLANK_LAST  = 9'h0BF,
    parameter logic [HW-1:0] HSYNC_FIRST  = 9'h1D0,
    parameter logic [HW-1:0] HSYNC_LAST   = 9'h1EF,
    parameter logic [VW-1:0] V_FIRST_NTSC = 9'h0F8,
    parameter logic [VW-1:0] V_FIRST_PAL  = 9'h0C8,
    parameter logic [VW-1:0] V_LAST       = 9'h1FF,
    parameter logic [VW-1:0] VACT_FIRST   = 9'h110,
    parameter logic [VW-1:0] VACT_LAST    = 9'h1EF,
    parameter int            VSYNC_LEN    = 8,
    parameter int            SYNC_DLY     = 3
) (
    input  logic           CLK,
    input  logic           RESET,
    videosync_gen_if.master bus
);

    logic [HW-1:0] pixelc;
    logic [VW-1:0] rasterc;
    logic          field;
    logic          line_start;
    logic          frame_start;
    logic          vmode_act;

    logic          h_wrap;
    logic          v_wrap;
    // {hsync_n, vsync_n, hblank, vblank}
    logic [3:0]    term_now;
    logic [3:0]    term_rst;
    logic [3:0]    term_out;

    function automatic logic [VW-1:0] v_first(input logic mode);
        return mode ? V_FIRST_PAL : V_FIRST_NTSC;
    endfunction

    // Inclusive window; FIRST > LAST means the window wraps through the end
    // of the count range.
    function automatic logic in_range_h(input logic [HW-1:0] v,
                                        input logic [HW-1:0] first,
                                        input logic [HW-1:0] last);
        if (first <= last)
            return (v >= first) && (v <= last);
        return (v >= first) || (v <= last);
    endfunction

    function automatic logic in_range_v(input logic [VW-1:0] v,
                                        input logic [VW-1:0] first,
                                        input logic [VW-1:0] last);
        if (first <= last)
            return (v >= first) && (v <= last);
        return (v >= first) || (v <= last);
    endfunction

    function automatic logic [3:0] decode(input logic [HW-1:0] p,
                                          input logic [VW-1:0] r,
                                          input logic          mode);
        logic [VW-1:0] vs_first;
        logic [VW-1:0] vs_last;
        vs_first = v_first(mode);
        vs_last  = vs_first + VW'(VSYNC_LEN - 1);
        return {~in_range_h(p, HSYNC_FIRST, HSYNC_LAST),
                ~in_range_v(r, vs_first, vs_last),
                in_range_h(p, HBLANK_FIRST, HBLANK_LAST),
                ~in_range_v(r, VACT_FIRST, VACT_LAST)};
    endfunction

    assign h_wrap   = (pixelc == H_LAST);
    assign v_wrap   = (rasterc == V_LAST);
    assign term_now = decode(pixelc, rasterc, vmode_act);
    // What the decode will be right after reset, so the delayed outputs are
    // already meaningful on the first post-reset cycle.
    assign term_rst = decode(H_FIRST, v_first(bus.VMODE), bus.VMODE);

    // Counter stage: pixel/line counters, field flag and start pulses.
    // VMODE is sampled only at the frame wrap so a frame never changes length.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pixelc      <= H_FIRST;
            rasterc     <= v_first(bus.VMODE);
            vmode_act   <= bus.VMODE;
            field       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (bus.CE_PIX) begin
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
            if (h_wrap) begin
                pixelc <= H_FIRST;
                field  <= ~field;
                if (v_wrap) begin
                    vmode_act <= bus.VMODE;
                    rasterc   <= v_first(bus.VMODE);
                end else begin
                    rasterc <= rasterc + 1'b1;
                end
            end else begin
                pixelc <= pixelc + 1'b1;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    // Sync/blank delay stage: SYNC_DLY taps advancing on CE_PIX.
    generate
        if (SYNC_DLY == 0) begin : g_nodly
            assign term_out = term_now;
        end else begin : g_dly
            logic [3:0] sync_p [SYNC_DLY];

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    for (int k = 0; k < SYNC_DLY; k++)
                        sync_p[k] <= term_rst;
                end else if (bus.CE_PIX) begin
                    sync_p[0] <= term_now;
                    for (int k = 1; k < SYNC_DLY; k++)
                        sync_p[k] <= sync_p[k-1];
                end
            end

            assign term_out = sync_p[SYNC_DLY-1];
        end
    endgenerate

    assign bus.PIXELC      = pixelc;
    assign bus.RASTERC     = rasterc;
    assign bus.FIELD       = field;
    assign bus.LINE_START  = line_start;
    assign bus.FRAME_START = frame_start;
    assign bus.VMODE_ACT   = vmode_act;
    assign bus.HSYNC       = term_out[3];
    assign bus.VSYNC       = term_out[2];
    assign bus.HBLANK      = term_out[1];
    assign bus.VBLANK      = term_out[0];

endmodule

// File: tb/tb_videosync_gen.sv
// ---------------------------------------------------------------------------
// tb_videosync_gen
// Drives three generator instances (default timing, a shrunken raster for
// frame-level behaviour, and a 10-bit zero-delay variant) from shared
// stimulus and compares every output each cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_videosync_gen;

    typedef struct packed {
        int hf, hl, hbf, hbl, hsf, hsl;
        int vfn, vfp, vl, vaf, val, vslen, dly;
    } cfg_t;

    typedef struct packed {
        int             pix;
        int             ras;
        bit             field;
        bit             ls;
        bit             fs;
        bit             mode;
        logic [7:0][3:0] hist;   // hist[0] = most recent decoded window set
    } mst_t;

    logic CLK;
    logic RESET;
    logic vm;
    int   n_checks;
    int   n_err;
    int   cyc;
    cfg_t ca, cb, cc;
    mst_t ma, mb, mc;

    videosync_gen_if #(.HW(9),  .VW(9)) ifa ();
    videosync_gen_if #(.HW(9),  .VW(9)) ifb ();
    videosync_gen_if #(.HW(10), .VW(9)) ifc ();

    videosync_gen dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa.master));

    videosync_gen #(
        .HW(9), .VW(9),
        .H_FIRST(9'h1E0), .H_LAST(9'h1FF),
        .HBLANK_FIRST(9'h1F8), .HBLANK_LAST(9'h1E3),
        .HSYNC_FIRST(9'h1FA), .HSYNC_LAST(9'h1FC),
        .V_FIRST_NTSC(9'h1F0), .V_FIRST_PAL(9'h1E8), .V_LAST(9'h1FF),
        .VACT_FIRST(9'h1F4), .VACT_LAST(9'h1FC),
        .VSYNC_LEN(2), .SYNC_DLY(1)
    ) dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb.master));

    videosync_gen #(
        .HW(10), .VW(9),
        .H_FIRST(10'h000), .H_LAST(10'h3FF),
        .HBLANK_FIRST(10'h380), .HBLANK_LAST(10'h03F),
        .HSYNC_FIRST(10'h3A0), .HSYNC_LAST(10'h3BF),
        .SYNC_DLY(0)
    ) dut_c (.CLK(CLK), .RESET(RESET), .bus(ifc.master));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    function automatic int vfirst(cfg_t c, bit m);
        return m ? c.vfp : c.vfn;
    endfunction

    // Position-in-window test along a circular line: v lies in the window if
    // walking forward from first reaches v no later than last.
    function automatic bit in_span(int v, int first, int last, int len);
        return ((v - first + len) % len) <= ((last - first + len) % len);
    endfunction

    function automatic logic [3:0] mdecode(cfg_t c, mst_t s);
        int  len;
        bit  hs_n, vs_n, hb, vb;
        len  = c.hl - c.hf + 1;
        hs_n = !in_span(s.pix, c.hsf, c.hsl, len);
        hb   = in_span(s.pix, c.hbf, c.hbl, len);
        vs_n = !((s.ras - vfirst(c, s.mode)) < c.vslen);
        vb   = !(s.ras >= c.vaf && s.ras <= c.val);
        return {hs_n, vs_n, hb, vb};
    endfunction

    function automatic mst_t mstep(cfg_t c, mst_t s, bit rst, bit ce, bit vmode);
        mst_t       n;
        logic [3:0] d;
        int         len;
        n   = s;
        len = c.hl - c.hf + 1;
        if (rst) begin
            n.pix   = c.hf;
            n.mode  = vmode;
            n.ras   = vfirst(c, vmode);
            n.field = 1'b0;
            n.ls    = 1'b0;
            n.fs    = 1'b0;
            d = mdecode(c, n);
            for (int k = 0; k < 8; k++) n.hist[k] = d;
        end else if (ce) begin
            n.hist = {s.hist[6:0], mdecode(c, s)};
            n.ls   = (s.pix == c.hl);
            n.fs   = n.ls && (s.ras == c.vl);
            n.pix  = c.hf + (s.pix - c.hf + 1) % len;
            if (n.ls) begin
                n.field = ~s.field;
                if (s.ras == c.vl) begin
                    n.mode = vmode;
                    n.ras  = vfirst(c, vmode);
                end else begin
                    n.ras = s.ras + 1;
                end
            end
        end else begin
            n.ls = 1'b0;
            n.fs = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [3:0] mout(cfg_t c, mst_t s);
        return (c.dly == 0) ? mdecode(c, s) : s.hist[c.dly-1];
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cmp_dut(string tag, cfg_t c, mst_t s,
                           logic [31:0] pix, logic [31:0] ras, logic [7:0] flags);
        logic [3:0] sy;
        sy = mout(c, s);
        chk({tag, "_pix"}, pix, 32'(s.pix));
        chk({tag, "_ras"}, ras, 32'(s.ras));
        // {FIELD, HSYNC, VSYNC, HBLANK, VBLANK, LINE_START, FRAME_START, VMODE_ACT}
        chk({tag, "_flags"}, 32'(flags),
            32'({s.field, sy[3], sy[2], sy[1], sy[0], s.ls, s.fs, s.mode}));
    endtask

    task automatic set_in(bit r, bit ce, bit m);
        RESET      = r;
        ifa.CE_PIX = ce;  ifa.VMODE = m;
        ifb.CE_PIX = ce;  ifb.VMODE = m;
        ifc.CE_PIX = ce;  ifc.VMODE = m;
    endtask

    task automatic step();
        @(posedge CLK);
        ma = mstep(ca, ma, RESET, ifa.CE_PIX, ifa.VMODE);
        mb = mstep(cb, mb, RESET, ifb.CE_PIX, ifb.VMODE);
        mc = mstep(cc, mc, RESET, ifc.CE_PIX, ifc.VMODE);
        #1;
        cyc++;
        cmp_dut("A", ca, ma, 32'(ifa.PIXELC), 32'(ifa.RASTERC),
                {ifa.FIELD, ifa.HSYNC, ifa.VSYNC, ifa.HBLANK, ifa.VBLANK,
                 ifa.LINE_START, ifa.FRAME_START, ifa.VMODE_ACT});
        cmp_dut("B", cb, mb, 32'(ifb.PIXELC), 32'(ifb.RASTERC),
                {ifb.FIELD, ifb.HSYNC, ifb.VSYNC, ifb.HBLANK, ifb.VBLANK,
                 ifb.LINE_START, ifb.FRAME_START, ifb.VMODE_ACT});
        cmp_dut("C", cc, mc, 32'(ifc.PIXELC), 32'(ifc.RASTERC),
                {ifc.FIELD, ifc.HSYNC, ifc.VSYNC, ifc.HBLANK, ifc.VBLANK,
                 ifc.LINE_START, ifc.FRAME_START, ifc.VMODE_ACT});
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int last_ls, last_fs, t0, t1, n;
        n_checks = 0;
        n_err    = 0;
        cyc      = 0;
        ca = '{hf:'h080, hl:'h1FF, hbf:'h1C0, hbl:'h0BF, hsf:'h1D0, hsl:'h1EF,
               vfn:'h0F8, vfp:'h0C8, vl:'h1FF, vaf:'h110, val:'h1EF, vslen:8, dly:3};
        cb = '{hf:'h1E0, hl:'h1FF, hbf:'h1F8, hbl:'h1E3, hsf:'h1FA, hsl:'h1FC,
               vfn:'h1F0, vfp:'h1E8, vl:'h1FF, vaf:'h1F4, val:'h1FC, vslen:2, dly:1};
        cc = '{hf:'h000, hl:'h3FF, hbf:'h380, hbl:'h03F, hsf:'h3A0, hsl:'h3BF,
               vfn:'h0F8, vfp:'h0C8, vl:'h1FF, vaf:'h110, val:'h1EF, vslen:8, dly:0};
        ma = '0;
        mb = '0;
        mc = '0;

        // Reset state, NTSC
        vm = 1'b0;
        set_in(1'b1, 1'b1, vm);
        step();
        step();
        chk("rst_pixelc",  32'(ifa.PIXELC),  32'h080);
        chk("rst_rasterc", 32'(ifa.RASTERC), 32'h0F8);
        chk("rst_field",   32'(ifa.FIELD),   32'd0);
        chk("rst_ls",      32'(ifa.LINE_START), 32'd0);
        chk("rst_hsync",   32'(ifa.HSYNC),   32'd1);
        chk("rst_vsync",   32'(ifa.VSYNC),   32'd0);
        chk("rst_hblank",  32'(ifa.HBLANK),  32'd1);
        chk("rst_vblank",  32'(ifa.VBLANK),  32'd1);

        // Continuous CE: line and frame periods
        set_in(1'b0, 1'b1, vm);
        last_ls = -1;
        last_fs = -1;
        for (int i = 0; i < 3 * 384; i++) begin
            step();
            if (ifa.LINE_START) begin
                if (last_ls >= 0) chk("line_period", 32'(cyc - last_ls), 32'd384);
                last_ls = cyc;
            end
            if (ifb.FRAME_START) begin
                if (last_fs >= 0) chk("frame_period_b", 32'(cyc - last_fs), 32'd512);
                last_fs = cyc;
            end
        end

        // 1-in-4 CE: HSYNC lands three enables after the window opens
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 1600; i++) begin
            set_in(1'b0, (i % 4) == 0, vm);
            step();
            if (t0 < 0 && ifa.PIXELC == 9'h1D0) t0 = cyc;
            if (t0 >= 0 && t1 < 0 && ifa.HSYNC == 1'b0) t1 = cyc;
        end
        chk("hsync_seen", 32'(t0 >= 0 && t1 >= 0), 32'd1);
        chk("hsync_delay", 32'(t1 - t0), 32'd12);

        // Random enables, mode flips and occasional resets
        for (int i = 0; i < 6000; i++) begin
            bit r, ce;
            r  = ($urandom_range(0, 1499) == 0);
            ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) vm = ~vm;
            set_in(r, ce, vm);
            step();
        end

        // Mid-line reset
        for (int i = 0; i < 400 && ifa.PIXELC != 9'h123; i++) begin
            set_in(1'b0, 1'b1, vm);
            step();
        end
        chk("reach_123", 32'(ifa.PIXELC), 32'h123);
        vm = 1'b0;
        set_in(1'b1, 1'b1, vm);
        step();
        chk("midrst_pixelc",  32'(ifa.PIXELC),  32'h080);
        chk("midrst_rasterc", 32'(ifa.RASTERC), 32'h0F8);
        chk("midrst_field",   32'(ifa.FIELD),   32'd0);
        chk("midrst_ls",      32'(ifa.LINE_START), 32'd0);

        // Reset with CE low into PAL, then hold with CE low
        vm = 1'b1;
        set_in(1'b1, 1'b0, vm);
        step();
        chk("palrst_mode",    32'(ifa.VMODE_ACT), 32'd1);
        chk("palrst_rasterc", 32'(ifa.RASTERC),   32'h0C8);
        set_in(1'b0, 1'b0, vm);
        step();
        step();
        chk("hold_pixelc", 32'(ifa.PIXELC), 32'h080);

        // Mid-frame mode change: NTSC frame still completes at 16 lines
        vm = 1'b0;
        set_in(1'b1, 1'b1, vm);
        step();
        n = 0;
        for (int i = 0; i < 1000 && !ifb.FRAME_START; i++) begin
            if (ifb.RASTERC == 9'h1F8) vm = 1'b1;
            set_in(1'b0, 1'b1, vm);
            step();
            n++;
        end
        chk("b_frame_len",  32'(n),               32'd512);
        chk("b_new_first",  32'(ifb.RASTERC),     32'h1E8);
        chk("b_new_mode",   32'(ifb.VMODE_ACT),   32'd1);

        // Mode change coinciding with the frame-wrap enable
        for (int i = 0; i < 1000 && !(ifb.PIXELC == 9'h1FF && ifb.RASTERC == 9'h1FF); i++) begin
            set_in(1'b0, 1'b1, vm);
            step();
        end
        chk("b_reach_wrap", 32'(ifb.PIXELC == 9'h1FF && ifb.RASTERC == 9'h1FF), 32'd1);
        vm = 1'b0;
        set_in(1'b0, 1'b1, vm);
        step();
        chk("wrap_sw_ras",  32'(ifb.RASTERC),     32'h1F0);
        chk("wrap_sw_mode", 32'(ifb.VMODE_ACT),   32'd0);
        chk("wrap_sw_fs",   32'(ifb.FRAME_START), 32'd1);

        // Zero-delay 10-bit variant: HBLANK follows PIXELC in the same cycle
        for (int i = 0; i < 1100 && ifc.PIXELC != 10'h37F; i++) begin
            set_in(1'b0, 1'b1, vm);
            step();
        end
        chk("c_reach_37f",  32'(ifc.PIXELC), 32'h37F);
        chk("c_hblank_off", 32'(ifc.HBLANK), 32'd0);
        step();
        chk("c_pix_380",    32'(ifc.PIXELC), 32'h380);
        chk("c_hblank_on",  32'(ifc.HBLANK), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
